// File: rtl/robot_motion_executor.sv
// Motion executor: turns one-hot front/turn/remove commands into timed
// actuator pulses and tracks heading, position, trash count and step budget.
module robot_motion_executor #(
    parameter int MOVE_CYCLES   = 4,
    parameter int TURN_CYCLES   = 2,
    parameter int REMOVE_CYCLES = 3,
    parameter int POS_W         = 8,
    parameter int CNT_W         = 8,
    parameter int STEP_LIMIT    = 200
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic                    cmd_front,
    input  logic                    cmd_turn,
    input  logic                    cmd_remove,
    output logic                    cmd_ready,
    output logic                    cmd_err,
    output logic                    motor_fwd,
    output logic                    motor_rot,
    output logic                    brush_on,
    output logic                    done,
    output logic [1:0]              heading,
    output logic signed [POS_W-1:0] pos_x,
    output logic signed [POS_W-1:0] pos_y,
    output logic [CNT_W-1:0]        removed_count,
    output logic [15:0]             step_count,
    output logic                    halted
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        TURN,
        REMOVE,
        HALT
    } state_t;

    localparam logic [POS_W-1:0] P_ONE = 1;
    localparam logic [CNT_W-1:0] C_ONE = 1;

    state_t      state;
    logic [15:0] op_cnt;
    logic [2:0]  cmd_bits;
    logic        one_hot;
    logic        multi;
    logic        last;
    logic [15:0] step_next;

    assign cmd_bits  = {cmd_front, cmd_turn, cmd_remove};
    assign one_hot   = $onehot(cmd_bits);
    assign multi     = (cmd_bits != 3'b000) && !one_hot;
    assign last      = (op_cnt == 16'd0);
    assign step_next = step_count + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            op_cnt        <= '0;
            cmd_ready     <= 1'b1;
            cmd_err       <= 1'b0;
            motor_fwd     <= 1'b0;
            motor_rot     <= 1'b0;
            brush_on      <= 1'b0;
            done          <= 1'b0;
            heading       <= 2'd0;
            pos_x         <= '0;
            pos_y         <= '0;
            removed_count <= '0;
            step_count    <= '0;
            halted        <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && one_hot) begin
                        cmd_ready <= 1'b0;
                        unique case (1'b1)
                            cmd_front: begin
                                state     <= MOVE;
                                op_cnt    <= 16'(MOVE_CYCLES - 1);
                                motor_fwd <= 1'b1;
                            end
                            cmd_turn: begin
                                state     <= TURN;
                                op_cnt    <= 16'(TURN_CYCLES - 1);
                                motor_rot <= 1'b1;
                            end
                            cmd_remove: begin
                                state    <= REMOVE;
                                op_cnt   <= 16'(REMOVE_CYCLES - 1);
                                brush_on <= 1'b1;
                            end
                        endcase
                    end else if (cmd_valid && multi) begin
                        cmd_err <= 1'b1;
                    end
                end
                MOVE: begin
                    if (last) begin
                        motor_fwd  <= 1'b0;
                        done       <= 1'b1;
                        step_count <= step_next;
                        unique case (heading)
                            2'd0: pos_y <= pos_y + P_ONE;
                            2'd1: pos_x <= pos_x + P_ONE;
                            2'd2: pos_y <= pos_y - P_ONE;
                            2'd3: pos_x <= pos_x - P_ONE;
                        endcase
                        // the move that spends the budget parks us for good
                        if (step_next == 16'(STEP_LIMIT)) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        op_cnt <= op_cnt - 16'd1;
                    end
                end
                TURN: begin
                    if (last) begin
                        motor_rot <= 1'b0;
                        done      <= 1'b1;
                        heading   <= heading + 2'd1;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        op_cnt <= op_cnt - 16'd1;
                    end
                end
                REMOVE: begin
                    if (last) begin
                        brush_on  <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        if (~&removed_count)
                            removed_count <= removed_count + C_ONE;
                    end else begin
                        op_cnt <= op_cnt - 16'd1;
                    end
                end
                HALT: begin
                    cmd_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
